ucode_sequencer: RTL and testbench

//  Expands macro instructions into micro-op sequences and drives the select line of the

---
 rtl/ucode_pkg.sv | 83 ++++++++
 rtl/ucode_rom.sv | 28 ++
 rtl/ucode_sequencer.sv | 127 ++++++++++++
 tb/tb_ucode_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ucode_pkg
//  Description : Shared constants for the micro-op sequencer: NOP encoding,
//                macro opcode, FSM state encoding, instruction field
//                positions, per-macro BASE/LEN tables and the micro-op ROM
//                contents.
//  Revision    : 1.0 - initial release
// ============================================================================
package ucode_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          UADDR_W      = 6;
    localparam int          MAX_UOPS     = 8;
    localparam int          LEN_W        = $clog2(MAX_UOPS + 1);
    localparam int          ROM_W        = INSTR_W + 3;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [6:0]  MACRO_OPCODE = 7'b0001011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_e;

    // Instruction field positions (RISC-V base encoding)
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int REG_W      = 5;

    // Substitution flag positions inside a ROM word
    localparam int SUB_RD_BIT  = 34;
    localparam int SUB_RS1_BIT = 33;
    localparam int SUB_RS2_BIT = 32;

    // First ROM address of each macro, indexed by funct3
    function automatic logic [5:0] base_of(input logic [2:0] f3);
        logic [5:0] b;
        case (f3)
            3'd0:    b = 6'd0;
            3'd1:    b = 6'd2;
            3'd2:    b = 6'd8;
            3'd3:    b = 6'd63;
            3'd4:    b = 6'd16;
            3'd5:    b = 6'd20;
            3'd6:    b = 6'd32;
            default: b = 6'd40;
        endcase
        return b;
    endfunction

    // Raw micro-op count of each macro; values above MAX_UOPS are clamped
    // by the sequencer, so entry 5 deliberately exceeds the limit.
    function automatic logic [3:0] len_of(input logic [2:0] f3);
        logic [3:0] l;
        case (f3)
            3'd0:    l = 4'd2;
            3'd1:    l = 4'd4;
            3'd2:    l = 4'd3;
            3'd3:    l = 4'd2;
            3'd4:    l = 4'd0;
            3'd5:    l = 4'd10;
            3'd6:    l = 4'd1;
            default: l = 4'd8;
        endcase
        return l;
    endfunction

    // ROM contents: an R-type micro-op whose fields are derived from the
    // address, so every entry is distinct. Flags: sub_rd on even addresses,
    // sub_rs1 when addr[1] is set, sub_rs2 when addr[2] is set.
    function automatic logic [ROM_W-1:0] rom_entry(input int unsigned a);
        logic [5:0]  a6;
        logic [31:0] uop;
        a6  = a[5:0];
        uop = {1'b0, a6, 5'(a6 + 6'd1), 5'(a6 + 6'd2), a6[2:0],
               5'(a6 + 6'd3), 7'b0110011};
        return {~a6[0], a6[1], a6[2], uop};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_rom.sv
`default_nettype none
// ============================================================================
//  Module      : ucode_rom
//  Description : 2^UADDR_W x 35-bit combinational-read micro-op ROM.
//                Word layout {sub_rd, sub_rs1, sub_rs2, uop[31:0]}.
//  Ports       : addr_i  - read address
//                data_o  - ROM word at addr_i (same cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module ucode_rom
    import ucode_pkg::*;
#(
    parameter int UADDR_W = 6
) (
    input  logic [UADDR_W-1:0] addr_i,
    output logic [ROM_W-1:0]   data_o
);

    logic [ROM_W-1:0] rom_w [2**UADDR_W];

    for (genvar i = 0; i < 2**UADDR_W; i++) begin : g_rom
        assign rom_w[i] = rom_entry(i);
    end

    assign data_o = rom_w[addr_i];

endmodule
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ucode_sequencer
//  Description : Expands custom-0 macro instructions into micro-op sequences
//                and drives the filtered/ucode mux select. Regular
//                instructions pass through (control=0); a macro costs one NOP
//                slot, then its micro-ops are issued one per decode_ready
//                cycle while fetch is stalled.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                filtered_instruction_i   - instruction from fetch filter
//                instr_valid_i            - filtered_instruction_i valid
//                decode_ready_i           - decode accepts mux output
//                flush_i                  - pipeline flush
//                fetch_stall_o            - hold fetch
//                ucode_instruction_o      - micro-op to the mux
//                control_o                - mux select (1 = ucode)
//                ucode_valid_o            - ucode_instruction_o valid
//                busy_o                   - sequence in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module ucode_sequencer
    import ucode_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] filtered_instruction_i,
    input  logic               instr_valid_i,
    input  logic               decode_ready_i,
    input  logic               flush_i,
    output logic               fetch_stall_o,
    output logic [INSTR_W-1:0] ucode_instruction_o,
    output logic               control_o,
    output logic               ucode_valid_o,
    output logic               busy_o
);

    state_e              state_q;
    logic [UADDR_W-1:0]  uaddr_q;
    logic [LEN_W-1:0]    remain_q;
    // Only the register fields of the macro are ever substituted, so only
    // those are kept.
    logic [REG_W-1:0]    mac_rd_q, mac_rs1_q, mac_rs2_q;

    logic                is_macro;
    logic [2:0]          funct3;
    logic [3:0]          len_raw;
    logic [LEN_W-1:0]    len_sel;
    logic [ROM_W-1:0]    rom_word;
    logic [INSTR_W-1:0]  uop_sub;
    logic                unused_bits;

    assign is_macro = instr_valid_i & (filtered_instruction_i[6:0] == MACRO_OPCODE);
    assign funct3   = filtered_instruction_i[FUNCT3_LSB +: 3];
    assign len_raw  = len_of(funct3);
    assign len_sel  = (32'(len_raw) > MAX_UOPS) ? LEN_W'(MAX_UOPS) : LEN_W'(len_raw);
    assign unused_bits = ^filtered_instruction_i[31:25];

    ucode_rom #(.UADDR_W(UADDR_W)) u_rom (
        .addr_i (uaddr_q),
        .data_o (rom_word)
    );

    always_comb begin
        uop_sub = rom_word[INSTR_W-1:0];
        if (rom_word[SUB_RD_BIT])  uop_sub[RD_LSB  +: REG_W] = mac_rd_q;
        if (rom_word[SUB_RS1_BIT]) uop_sub[RS1_LSB +: REG_W] = mac_rs1_q;
        if (rom_word[SUB_RS2_BIT]) uop_sub[RS2_LSB +: REG_W] = mac_rs2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            uaddr_q   <= '0;
            remain_q  <= '0;
            mac_rd_q  <= '0;
            mac_rs1_q <= '0;
            mac_rs2_q <= '0;
        end else if (flush_i) begin
            // Pending micro-ops are dropped; a macro in IDLE is not accepted.
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_macro && decode_ready_i) begin
                        mac_rd_q  <= filtered_instruction_i[RD_LSB  +: REG_W];
                        mac_rs1_q <= filtered_instruction_i[RS1_LSB +: REG_W];
                        mac_rs2_q <= filtered_instruction_i[RS2_LSB +: REG_W];
                        uaddr_q   <= UADDR_W'(base_of(funct3));
                        remain_q  <= len_sel;
                        // A zero-length macro is just the NOP slot.
                        state_q   <= (len_sel != '0) ? ST_SEQ : ST_IDLE;
                    end
                end
                ST_SEQ: begin
                    if (decode_ready_i) begin
                        uaddr_q  <= uaddr_q + UADDR_W'(1);
                        remain_q <= remain_q - LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The macro slot itself must show control=1 in the same cycle it is
    // presented, so outputs decode state plus the live input.
    always_comb begin
        fetch_stall_o       = 1'b0;
        busy_o              = 1'b0;
        control_o           = is_macro;
        ucode_valid_o       = is_macro;
        ucode_instruction_o = NOP;
        if (state_q == ST_SEQ) begin
            fetch_stall_o       = 1'b1;
            busy_o              = 1'b1;
            control_o           = 1'b1;
            ucode_valid_o       = 1'b1;
            ucode_instruction_o = uop_sub;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucode_sequencer
//  Description : Self-checking bench for ucode_sequencer. A behavioural
//                model predicts the outputs of every cycle; predictions are
//                queued when stimulus is applied and compared when the DUT
//                outputs are sampled at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] filtered_instruction;
    logic        instr_valid, decode_ready, flush;
    logic        fetch_stall, control, ucode_valid, busy;
    logic [31:0] ucode_instruction;

    int n_checks = 0;
    int n_fail   = 0;
    int n_uops   = 0;

    always #5 clk = ~clk;

    ucode_sequencer dut (
        .clk                    (clk),
        .rst                    (rst),
        .filtered_instruction_i (filtered_instruction),
        .instr_valid_i          (instr_valid),
        .decode_ready_i         (decode_ready),
        .flush_i                (flush),
        .fetch_stall_o          (fetch_stall),
        .ucode_instruction_o    (ucode_instruction),
        .control_o              (control),
        .ucode_valid_o          (ucode_valid),
        .busy_o                 (busy)
    );

    typedef struct {
        logic        stall;
        logic        ctl;
        logic        vld;
        logic        bsy;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int          base_t[8] = '{0, 2, 8, 63, 16, 20, 32, 40};
    int          len_t[8]  = '{2, 4, 3, 2, 0, 10, 1, 8};
    logic        m_seq;
    logic [5:0]  m_uaddr;
    int          m_remain;
    logic [31:0] m_macro;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int f3, input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0001011};
    endfunction

    function automatic logic [34:0] tb_rom(input logic [5:0] a);
        logic [31:0] u;
        u = {1'b0, a, 5'(a + 6'd1), 5'(a + 6'd2), a[2:0], 5'(a + 6'd3), 7'b0110011};
        return {~a[0], a[1], a[2], u};
    endfunction

    function automatic exp_t model_out(input logic [31:0] ins, input logic v);
        exp_t e;
        logic [34:0] w;
        logic is_m;
        is_m = v && (ins[6:0] == 7'b0001011);
        if (m_seq) begin
            w = tb_rom(m_uaddr);
            e.ins = w[31:0];
            if (w[34]) e.ins[11:7]  = m_macro[11:7];
            if (w[33]) e.ins[19:15] = m_macro[19:15];
            if (w[32]) e.ins[24:20] = m_macro[24:20];
            e.stall = 1'b1; e.ctl = 1'b1; e.vld = 1'b1; e.bsy = 1'b1;
        end else begin
            e.ins = 32'h0000_0013;
            e.stall = 1'b0; e.bsy = 1'b0; e.ctl = is_m; e.vld = is_m;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_seq = 1'b0; m_uaddr = '0; m_remain = 0; m_macro = '0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic v, input logic rdy,
                              input logic fl, input logic rs);
        int l;
        if (rs) begin
            model_reset();
        end else if (fl) begin
            m_seq = 1'b0; m_remain = 0;
        end else if (!m_seq) begin
            if (v && ins[6:0] == 7'b0001011 && rdy) begin
                l = len_t[ins[14:12]];
                if (l > 8) l = 8;
                m_macro  = ins;
                m_uaddr  = 6'(base_t[ins[14:12]]);
                m_remain = l;
                m_seq    = (l != 0);
            end
        end else if (rdy) begin
            m_uaddr = m_uaddr + 6'd1;
            if (m_remain == 1) m_seq = 1'b0;
            m_remain = m_remain - 1;
        end
    endtask

    // One clock cycle: apply stimulus, queue prediction, compare, advance.
    task automatic cyc(input logic [31:0] ins, input logic v, input logic rdy,
                       input logic fl, input logic rs);
        exp_t e;
        filtered_instruction = ins;
        instr_valid  = v;
        decode_ready = rdy;
        flush        = fl;
        rst          = rs;
        sb.push_back(model_out(ins, v));
        @(negedge clk);
        e = sb.pop_front();
        check("fetch_stall",       {31'b0, fetch_stall}, {31'b0, e.stall});
        check("control",           {31'b0, control},     {31'b0, e.ctl});
        check("ucode_valid",       {31'b0, ucode_valid}, {31'b0, e.vld});
        check("busy",              {31'b0, busy},        {31'b0, e.bsy});
        check("ucode_instruction", ucode_instruction,    e.ins);
        if (busy && rdy && !rs) n_uops++;
        model_step(ins, v, rdy, fl, rs);
        @(posedge clk);
        #1;
    endtask

    // Present a macro, hold it while fetch is stalled; decode_ready drops
    // for two cycles starting at sequence cycle stall_at (-1: never).
    task automatic run_macro(input logic [31:0] ins, input int stall_at, input int exp_len);
        int k;
        n_uops = 0;
        cyc(ins, 1'b1, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (m_seq && k < 40) begin
            cyc(ins, 1'b1, !(k == stall_at || k == stall_at + 1), 1'b0, 1'b0);
            k++;
        end
        check("uop_count", 32'(n_uops), 32'(exp_len));
    endtask

    localparam logic [31:0] PASS_I = 32'h0050_0093;

    initial begin
        logic [31:0] held;
        filtered_instruction = '0;
        instr_valid = 1'b0; decode_ready = 1'b0; flush = 1'b0; rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        // Reset state
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_ucode_instruction", ucode_instruction, 32'h0000_0013);
        check("rst_control", {31'b0, control}, 32'd0);

        // Passthrough
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);
        check("pass_control", {31'b0, control}, 32'd0);
        cyc(mk(2, 5, 6, 7), 1'b0, 1'b1, 1'b0, 1'b0);  // invalid macro ignored

        // Macro funct3=2 (BASE=8, LEN=3), rd=5
        run_macro(mk(2, 5, 6, 7), -1, 3);
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);
        check("after_seq_control", {31'b0, control}, 32'd0);

        // decode_ready low for two cycles mid-sequence
        run_macro(mk(1, 9, 10, 11), 1, 4);

        // Zero-length macro, then BASE=63 wrap
        run_macro(mk(4, 3, 4, 5), -1, 0);
        run_macro(mk(3, 12, 13, 14), -1, 2);

        // Over-long macro clamped to MAX_UOPS
        run_macro(mk(5, 17, 18, 19), -1, 8);

        // Flush on the 2nd micro-op of a LEN=4 macro
        held = mk(1, 21, 22, 23);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(held, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_stall", {31'b0, fetch_stall}, 32'd0);
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);

        // Flush together with decode_ready in SEQ, and flush on macro accept
        held = mk(7, 1, 2, 3);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(held, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(mk(2, 5, 6, 7), 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_accept_busy", {31'b0, busy}, 32'd0);
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset mid-sequence, then a new macro
        held = mk(7, 30, 29, 28);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(held, 1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_ins", ucode_instruction, 32'h0000_0013);
        cyc(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_macro(mk(2, 5, 6, 7), -1, 3);
        cyc(PASS_I, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
